// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 definitions for the execute-stage multiply unit.
//   OP_REG          : major opcode of register-register ALU/M-extension ops
//   F3_MUL..F3_MULHU: funct3 encodings of the four RV32M multiply flavours
//   MUL_ROB_W       : width of the ROB index carried in the tag
//   mul_tag_t       : bookkeeping that travels alongside each product
//   ext_rs1/ext_rs2 : 33-bit operand extension selected by funct3
//   is_high_word    : selects the upper product word for MULH/MULHSU/MULHU
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;

   localparam int MUL_ROB_W = 4;

   typedef struct packed {
      logic [4:0]           rd;
      logic                 write_enable;
      logic [MUL_ROB_W-1:0] rob_idx;
      logic [2:0]           exception_vector;
   } mul_tag_t;

   // rs1 is treated as signed for everything except MULHU. For MUL the
   // extension is irrelevant because only the low word is kept.
   function automatic logic [32:0] ext_rs1(input logic [2:0] funct3,
                                           input logic [31:0] value);
      return {(funct3 != F3_MULHU) & value[31], value};
   endfunction

   // rs2 is signed only for MUL and MULH.
   function automatic logic [32:0] ext_rs2(input logic [2:0] funct3,
                                           input logic [31:0] value);
      return {((funct3 == F3_MUL) | (funct3 == F3_MULH)) & value[31], value};
   endfunction

   function automatic logic is_high_word(input logic [2:0] funct3);
      return funct3 != F3_MUL;
   endfunction

endpackage

// File: rtl/mul_stage_reg.sv
// ----------------------------------------------------------------------------
// mul_stage_reg
// One pipeline slot of the multiply unit: a valid bit, the instruction tag
// and a data payload of DATA_W bits.
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   stall          : hold the slot contents
//   flush          : clear the valid bit (wins over stall)
//   load_valid/tag/data : next contents from the previous slot
//   valid/tag/data : current slot contents
// ----------------------------------------------------------------------------
module mul_stage_reg
   import riscv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              load_valid,
   input  mul_tag_t          load_tag,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output mul_tag_t          tag,
   output logic [DATA_W-1:0] data
);

   // Flush only needs to drop the valid bit; tag and data of an invalid
   // slot are never looked at downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (!stall) begin
         valid <= load_valid;
         tag   <= load_tag;
         data  <= load_data;
      end
   end

endmodule

// File: rtl/mul_pipeline.sv
// ----------------------------------------------------------------------------
// mul_pipeline
// Fixed-latency RV32M multiply unit (MUL/MULH/MULHSU/MULHU). An operation
// sampled at edge k appears on the registered outputs after edge k+STAGES.
//   clk, reset            : rising-edge clock, async active-high reset
//   in_valid, in_funct3   : issue strobe and RV32M funct3 (divides ignored)
//   in_data_rs1/rs2       : operands
//   in_rd, in_write_enable, in_rob_idx, in_exception_vector : tag fields
//   in_d_cache_stall      : freeze every slot and the output register
//   in_flush              : drop everything in flight (beats stall/issue)
//   in_check_rd           : register queried by the hazard unit
//   out_valid, out_result, out_rd, out_write_enable, out_rob_idx,
//   out_exception_vector  : registered result slot
//   out_busy              : any slot (including output) holds an operation
//   out_rd_pending        : an in-flight writer targets in_check_rd
// ----------------------------------------------------------------------------
module mul_pipeline
   import riscv_pkg::*;
#(
   parameter int STAGES    = 5,
   parameter int ROB_IDX_W = MUL_ROB_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [2:0]           in_funct3,
   input  logic [31:0]          in_data_rs1,
   input  logic [31:0]          in_data_rs2,
   input  logic [4:0]           in_rd,
   input  logic                 in_write_enable,
   input  logic [ROB_IDX_W-1:0] in_rob_idx,
   input  logic [2:0]           in_exception_vector,
   input  logic                 in_d_cache_stall,
   input  logic                 in_flush,
   input  logic [4:0]           in_check_rd,
   output logic                 out_valid,
   output logic [31:0]          out_result,
   output logic [4:0]           out_rd,
   output logic                 out_write_enable,
   output logic [ROB_IDX_W-1:0] out_rob_idx,
   output logic [2:0]           out_exception_vector,
   output logic                 out_busy,
   output logic                 out_rd_pending
);

   // First slot payload: {high_word_select, rs1 extended, rs2 extended}.
   localparam int OP_W = 67;

   logic              accept;
   mul_tag_t          issue_tag;
   logic [OP_W-1:0]   issue_ops;

   logic [STAGES-1:0] stage_valid;
   mul_tag_t          stage_tag [STAGES];
   logic [OP_W-1:0]   op_data;
   logic [31:0]       res_chain [STAGES];

   logic [63:0]       product;
   logic              pending;

   // Divide encodings (funct3[2]=1) belong to another unit, so they enter
   // the first slot as a bubble.
   assign accept    = in_valid & ~in_funct3[2];
   assign issue_ops = {is_high_word(in_funct3),
                       ext_rs1(in_funct3, in_data_rs1),
                       ext_rs2(in_funct3, in_data_rs2)};

   always_comb begin
      issue_tag                  = '0;
      issue_tag.rd               = in_rd;
      issue_tag.write_enable     = in_write_enable;
      issue_tag.rob_idx          = in_rob_idx;
      issue_tag.exception_vector = in_exception_vector;
   end

   // Sign-extending both 33-bit operands to 64 bits and keeping the low 64
   // bits of an unsigned multiply gives the truncated two's-complement
   // product, so no signed multiplier is needed.
   assign product = {{31{op_data[65]}}, op_data[65:33]} *
                    {{31{op_data[32]}}, op_data[32:0]};
   assign res_chain[0] = op_data[66] ? product[63:32] : product[31:0];

   // Slot 0 holds the extended operands; the multiply sits between slot 0
   // and slot 1, and later slots only carry the selected 32-bit word.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_ops
         mul_stage_reg #(.DATA_W(OP_W)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .stall      (in_d_cache_stall),
            .flush      (in_flush),
            .load_valid (accept),
            .load_tag   (issue_tag),
            .load_data  (issue_ops),
            .valid      (stage_valid[0]),
            .tag        (stage_tag[0]),
            .data       (op_data)
         );
      end else begin : g_res
         mul_stage_reg #(.DATA_W(32)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .stall      (in_d_cache_stall),
            .flush      (in_flush),
            .load_valid (stage_valid[i-1]),
            .load_tag   (stage_tag[i-1]),
            .load_data  (res_chain[i-1]),
            .valid      (stage_valid[i]),
            .tag        (stage_tag[i]),
            .data       (res_chain[i])
         );
      end
   end

   // Output slot adds the final edge of latency. Write enable is gated with
   // valid here so an empty slot never requests a register write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid            <= 1'b0;
         out_result           <= '0;
         out_rd               <= '0;
         out_write_enable     <= 1'b0;
         out_rob_idx          <= '0;
         out_exception_vector <= '0;
      end else if (in_flush) begin
         out_valid            <= 1'b0;
         out_write_enable     <= 1'b0;
      end else if (!in_d_cache_stall) begin
         out_valid            <= stage_valid[STAGES-1];
         out_result           <= res_chain[STAGES-1];
         out_rd               <= stage_tag[STAGES-1].rd;
         out_write_enable     <= stage_valid[STAGES-1] &
                                 stage_tag[STAGES-1].write_enable;
         out_rob_idx          <= stage_tag[STAGES-1].rob_idx;
         out_exception_vector <= stage_tag[STAGES-1].exception_vector;
      end
   end

   // Hazard lookup across every slot plus the output slot; x0 never
   // creates a dependency.
   always_comb begin
      pending = out_write_enable & (out_rd == in_check_rd);
      for (int i = 0; i < STAGES; i++) begin
         if (stage_valid[i] && stage_tag[i].write_enable &&
             (stage_tag[i].rd == in_check_rd)) begin
            pending = 1'b1;
         end
      end
   end

   assign out_rd_pending = pending & (in_check_rd != 5'd0);
   assign out_busy       = (|stage_valid) | out_valid;

endmodule

// File: tb/tb_mul_pipeline.sv
// ----------------------------------------------------------------------------
// tb_mul_pipeline
// Self-checking bench for mul_pipeline. A list of in-flight operations, each
// with its age in unstalled edges, predicts every output after each edge.
// ----------------------------------------------------------------------------
module tb_mul_pipeline;

   localparam int STAGES = 5;
   localparam int ROB_W  = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [2:0]       in_funct3;
   logic [31:0]      in_data_rs1;
   logic [31:0]      in_data_rs2;
   logic [4:0]       in_rd;
   logic             in_write_enable;
   logic [ROB_W-1:0] in_rob_idx;
   logic [2:0]       in_exception_vector;
   logic             in_d_cache_stall;
   logic             in_flush;
   logic [4:0]       in_check_rd;
   logic             out_valid;
   logic [31:0]      out_result;
   logic [4:0]       out_rd;
   logic             out_write_enable;
   logic [ROB_W-1:0] out_rob_idx;
   logic [2:0]       out_exception_vector;
   logic             out_busy;
   logic             out_rd_pending;

   mul_pipeline #(.STAGES(STAGES), .ROB_IDX_W(ROB_W)) dut (
      .clk                  (clk),
      .reset                (reset),
      .in_valid             (in_valid),
      .in_funct3            (in_funct3),
      .in_data_rs1          (in_data_rs1),
      .in_data_rs2          (in_data_rs2),
      .in_rd                (in_rd),
      .in_write_enable      (in_write_enable),
      .in_rob_idx           (in_rob_idx),
      .in_exception_vector  (in_exception_vector),
      .in_d_cache_stall     (in_d_cache_stall),
      .in_flush             (in_flush),
      .in_check_rd          (in_check_rd),
      .out_valid            (out_valid),
      .out_result           (out_result),
      .out_rd               (out_rd),
      .out_write_enable     (out_write_enable),
      .out_rob_idx          (out_rob_idx),
      .out_exception_vector (out_exception_vector),
      .out_busy             (out_busy),
      .out_rd_pending       (out_rd_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               age;
      logic [31:0]      result;
      logic [4:0]       rd;
      logic             we;
      logic [ROB_W-1:0] rob;
      logic [2:0]       exc;
   } op_t;

   op_t inflight[$];
   int  vector_count = 0;
   int  miss_count   = 0;

   // Reference product straight from the ISA rules, using 64-bit arithmetic.
   function automatic logic [31:0] ref_mul(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint unsigned ea, eb, p;
      ea = (f3 == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
      eb = (f3 == 3'b000 || f3 == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (f3 == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic we,
                                input logic [ROB_W-1:0] rob,
                                input logic [2:0] exc);
      in_valid            = v;
      in_funct3           = f3;
      in_data_rs1         = a;
      in_data_rs2         = b;
      in_rd               = rd;
      in_write_enable     = we;
      in_rob_idx          = rob;
      in_exception_vector = exc;
   endtask

   // Called at the rising edge with the same inputs the DUT samples.
   task automatic modelEdge();
      if (reset || in_flush) begin
         inflight.delete();
      end else if (!in_d_cache_stall) begin
         foreach (inflight[i]) inflight[i].age++;
         while (inflight.size() > 0 && inflight[0].age > STAGES)
            void'(inflight.pop_front());
         if (in_valid && !in_funct3[2])
            inflight.push_back('{0, ref_mul(in_funct3, in_data_rs1, in_data_rs2),
                                 in_rd, in_write_enable, in_rob_idx,
                                 in_exception_vector});
      end
   endtask

   task automatic compareAll();
      logic exp_valid = 1'b0;
      logic exp_pend  = 1'b0;
      op_t  head;
      head = '{0, 32'h0, 5'h0, 1'b0, '0, 3'h0};
      foreach (inflight[i]) begin
         if (inflight[i].age == STAGES) begin
            exp_valid = 1'b1;
            head      = inflight[i];
         end
         if (inflight[i].we && inflight[i].rd == in_check_rd && in_check_rd != 5'd0)
            exp_pend = 1'b1;
      end
      checkOutput("valid", {31'b0, out_valid}, {31'b0, exp_valid});
      checkOutput("busy", {31'b0, out_busy}, {31'b0, inflight.size() != 0});
      checkOutput("rd_pending", {31'b0, out_rd_pending}, {31'b0, exp_pend});
      if (exp_valid) begin
         checkOutput("result", out_result, head.result);
         checkOutput("rd", {27'b0, out_rd}, {27'b0, head.rd});
         checkOutput("write_enable", {31'b0, out_write_enable}, {31'b0, head.we});
         checkOutput("rob_idx", {28'b0, out_rob_idx}, {28'b0, head.rob});
         checkOutput("exc_vec", {29'b0, out_exception_vector}, {29'b0, head.exc});
      end else begin
         checkOutput("idle_write_enable", {31'b0, out_write_enable}, 32'h0);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      modelEdge();
      #1;
      compareAll();
   endtask

   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   logic [2:0]  plan_f3  [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
   logic [31:0] plan_a   [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] plan_b   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] plan_exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset            = 1'b1;
      in_d_cache_stall = 1'b0;
      in_flush         = 1'b0;
      in_check_rd      = 5'd0;
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, '0, 3'b0);

      // Reset state, before and across clock edges.
      #1;
      checkOutput("reset_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("reset_result", out_result, 32'h0);
      checkOutput("reset_busy", {31'b0, out_busy}, 32'h0);
      stepCycle();
      stepCycle();
      reset = 1'b0;
      idleCycles(1);

      // Directed products with fixed expected words.
      for (int t = 0; t < 4; t++) begin
         applyStimulus(1'b1, plan_f3[t], plan_a[t], plan_b[t], 5'd5, 1'b1, 4'd3, 3'b0);
         stepCycle();
         idleCycles(STAGES);
         checkOutput("plan_valid", {31'b0, out_valid}, 32'h1);
         checkOutput("plan_result", out_result, plan_exp[t]);
      end
      idleCycles(2);

      // Back-to-back issue with a two-cycle stall after the second op.
      applyStimulus(1'b1, 3'b000, 32'd11, 32'd13, 5'd1, 1'b1, 4'd1, 3'b000);
      stepCycle();
      applyStimulus(1'b1, 3'b001, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2, 1'b1, 4'd2, 3'b101);
      stepCycle();
      applyStimulus(1'b1, 3'b011, 32'hCAFE_F00D, 32'h9ABC_DEF0, 5'd3, 1'b0, 4'd4, 3'b010);
      in_d_cache_stall = 1'b1;
      stepCycle();
      stepCycle();
      in_d_cache_stall = 1'b0;
      stepCycle();
      idleCycles(STAGES + 2);

      // Flush beats a simultaneous stall and issue.
      applyStimulus(1'b1, 3'b000, 32'd3, 32'd4, 5'd9, 1'b1, 4'd5, 3'b0);
      stepCycle();
      applyStimulus(1'b1, 3'b010, 32'd5, 32'd6, 5'd10, 1'b1, 4'd6, 3'b0);
      stepCycle();
      applyStimulus(1'b1, 3'b001, 32'd7, 32'd8, 5'd11, 1'b1, 4'd7, 3'b0);
      in_flush         = 1'b1;
      in_d_cache_stall = 1'b1;
      stepCycle();
      checkOutput("flush_busy", {31'b0, out_busy}, 32'h0);
      in_flush         = 1'b0;
      in_d_cache_stall = 1'b0;
      idleCycles(STAGES + 2);

      // Asynchronous reset pulse while a result sits on the outputs.
      applyStimulus(1'b1, 3'b000, 32'h1234, 32'h5678, 5'd12, 1'b1, 4'd8, 3'b0);
      stepCycle();
      idleCycles(STAGES);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("async_result", out_result, 32'h0);
      checkOutput("async_busy", {31'b0, out_busy}, 32'h0);
      inflight.delete();
      #1;
      reset = 1'b0;
      applyStimulus(1'b1, 3'b011, 32'hFFFF_0000, 32'h0001_0001, 5'd13, 1'b1, 4'd9, 3'b0);
      stepCycle();
      idleCycles(STAGES + 1);

      // Hazard lookup on rd=7.
      in_check_rd = 5'd7;
      applyStimulus(1'b1, 3'b000, 32'd2, 32'd3, 5'd7, 1'b1, 4'd10, 3'b0);
      stepCycle();
      checkOutput("pending_rd7", {31'b0, out_rd_pending}, 32'h1);
      idleCycles(1);
      in_check_rd = 5'd0;
      #1;
      checkOutput("pending_rd0", {31'b0, out_rd_pending}, 32'h0);
      in_check_rd = 5'd7;
      idleCycles(STAGES + 1);
      checkOutput("pending_retired", {31'b0, out_rd_pending}, 32'h0);
      applyStimulus(1'b1, 3'b100, 32'd9, 32'd3, 5'd7, 1'b1, 4'd11, 3'b0);
      stepCycle();
      checkOutput("divide_busy", {31'b0, out_busy}, 32'h0);
      idleCycles(1);

      // Random traffic with occasional stalls and flushes.
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                       pickOperand(), pickOperand(), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       3'($urandom_range(0, 7)));
         in_d_cache_stall = ($urandom_range(0, 7) == 0);
         in_flush         = ($urandom_range(0, 39) == 0);
         in_check_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
         stepCycle();
      end
      in_d_cache_stall = 1'b0;
      in_flush         = 1'b0;
      idleCycles(STAGES + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
